// File: rtl/mdu_hilo_unit_if.sv
// mdu_hilo_unit_if: ID->EXE op bus and EXE result bus of the multiply/divide/HI-LO unit.
// Latency: none, signal bundle only.
// Backpressure: in_valid/in_ready on the op side, out_valid/out_ready on the result side.
// Signals: in_valid/in_ready/in_op/in_src1/in_src2 (op side), out_valid/out_ready/out_hi/
//   out_lo/out_dest (result side), busy (unit not idle; decode stalls mfhi/mflo on it).
interface mdu_hilo_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_hi;
   logic [31:0] out_lo;
   logic [1:0]  out_dest;
   logic        busy;

   // master: decode/EXE side that issues ops and takes results
   modport master (
      output in_valid, in_op, in_src1, in_src2, out_ready,
      input  in_ready, out_valid, out_hi, out_lo, out_dest, busy
   );

   // slave: the unit itself
   modport slave (
      input  in_valid, in_op, in_src1, in_src2, out_ready,
      output in_ready, out_valid, out_hi, out_lo, out_dest, busy
   );
endinterface

// File: rtl/mdu_hilo_unit.sv
// mdu_hilo_unit: multi-cycle multiply/divide and mthi/mtlo unit of the EXE stage.
// Latency: div/divu 32 cycles accept->out_valid; mthi/mtlo/illegal and mult/multu 1 cycle
//   (mult/multu 32 cycles when MDU_ITER_MUL_EN is defined).
// Backpressure: single outstanding op; result held in DONE until out_ready, in_ready low meanwhile.
// Ports: clk; reset (synchronous, active-high); flush (drops any in-flight op, wins over accept);
//   mdu: slave side of mdu_hilo_unit_if (op bus, result bus {out_hi,out_lo,out_dest}, busy).
// Config: define MDU_ITER_MUL_EN for a 32-step shift-add multiplier; default is a single-cycle multiply.
module mdu_hilo_unit #(
   parameter int DIV_STEPS = 32   // restoring iterations; must equal the 32-bit operand width
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   mdu_hilo_unit_if.slave mdu
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   // One restoring-division step on {rem, quo}: shift the next dividend bit into the
   // remainder, subtract the divisor if it fits, and shift the quotient bit in.
   function automatic logic [63:0] div_step(input logic [31:0] rem,
                                            input logic [31:0] quo,
                                            input logic [31:0] dvs);
      logic [32:0] sh;
      logic [32:0] diff;
      sh   = {rem, quo[31]};
      diff = sh - {1'b0, dvs};
      if (diff[32]) div_step = {sh[31:0], quo[30:0], 1'b0};
      else          div_step = {diff[31:0], quo[30:0], 1'b1};
   endfunction

`ifdef MDU_ITER_MUL_EN
   // One shift-add step: the multiplier sits in the low word and shifts out LSB first,
   // partial products accumulate in the high word.
   function automatic logic [63:0] mul_step(input logic [31:0] hi,
                                            input logic [31:0] lo,
                                            input logic [31:0] mcand);
      logic [32:0] sum;
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
      mul_step = {sum, lo[31:1]};
   endfunction
`endif

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;     // quotient/product bits already produced
   logic [31:0] acc_hi_q, acc_hi_d;   // remainder / partial product high word
   logic [31:0] acc_lo_q, acc_lo_d;   // quotient / multiplier-and-product low word
   logic [31:0] opb_q, opb_d;         // divisor or multiplicand magnitude
   logic        neg_quo_q, neg_quo_d; // negate quotient/product at the end
   logic        neg_rem_q, neg_rem_d; // negate remainder at the end
   logic        div_zero_q, div_zero_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [1:0]  dest_q, dest_d;

   logic        accept;
   logic        is_signed;
   logic [31:0] src1_mag;
   logic [31:0] src2_mag;
   logic        neg_quo_in;
   logic        neg_rem_in;
   logic [63:0] step;

   // flush cancels an op presented in the same cycle
   assign accept     = mdu.in_valid && (state_q == IDLE) && !flush;
   assign is_signed  = (mdu.in_op == OP_MULT) || (mdu.in_op == OP_DIV);
   assign src1_mag   = (is_signed && mdu.in_src1[31]) ? -mdu.in_src1 : mdu.in_src1;
   assign src2_mag   = (is_signed && mdu.in_src2[31]) ? -mdu.in_src2 : mdu.in_src2;
   assign neg_quo_in = is_signed && (mdu.in_src1[31] ^ mdu.in_src2[31]);
   assign neg_rem_in = is_signed && mdu.in_src1[31];

`ifndef MDU_ITER_MUL_EN
   logic [63:0] prod_mag;
   assign prod_mag = {32'd0, src1_mag} * {32'd0, src2_mag};
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opb_d      = opb_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dest_d     = dest_q;
      step       = 64'd0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               neg_quo_d  = neg_quo_in;
               neg_rem_d  = neg_rem_in;
               div_zero_d = (mdu.in_src2 == 32'd0);
               case (mdu.in_op)
                  OP_MULT, OP_MULTU: begin
`ifdef MDU_ITER_MUL_EN
                     // first step runs in the accept cycle so 32 steps end 32 cycles later
                     step     = mul_step(32'd0, src2_mag, src1_mag);
                     acc_hi_d = step[63:32];
                     acc_lo_d = step[31:0];
                     opb_d    = src1_mag;
                     count_d  = 5'd1;
                     state_d  = MUL;
`else
                     {hi_d, lo_d} = neg_quo_in ? -prod_mag : prod_mag;
                     dest_d       = 2'b11;
                     state_d      = DONE;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     // first step runs in the accept cycle so 32 steps end 32 cycles later
                     step     = div_step(32'd0, src1_mag, src2_mag);
                     acc_hi_d = step[63:32];
                     acc_lo_d = step[31:0];
                     opb_d    = src2_mag;
                     count_d  = 5'd1;
                     state_d  = DIV;
                  end
                  OP_MTHI: begin
                     hi_d    = mdu.in_src1;
                     lo_d    = 32'd0;
                     dest_d  = 2'b01;
                     state_d = DONE;
                  end
                  OP_MTLO: begin
                     hi_d    = 32'd0;
                     lo_d    = mdu.in_src1;
                     dest_d  = 2'b10;
                     state_d = DONE;
                  end
                  default: begin
                     hi_d    = 32'd0;
                     lo_d    = 32'd0;
                     dest_d  = 2'b00;
                     state_d = DONE;
                  end
               endcase
            end
         end

         DIV: begin
            step     = div_step(acc_hi_q, acc_lo_q, opb_q);
            acc_hi_d = step[63:32];
            acc_lo_d = step[31:0];
            count_d  = count_q + 5'd1;
            if (count_q == LAST_STEP) begin
               // x/0 yields all-ones quotient; the remainder is |dividend| re-signed, i.e. src1
               lo_d    = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -step[31:0] : step[31:0]);
               hi_d    = neg_rem_q ? -step[63:32] : step[63:32];
               dest_d  = 2'b11;
               count_d = 5'd0;
               state_d = DONE;
            end
         end

         MUL: begin
`ifdef MDU_ITER_MUL_EN
            step     = mul_step(acc_hi_q, acc_lo_q, opb_q);
            acc_hi_d = step[63:32];
            acc_lo_d = step[31:0];
            count_d  = count_q + 5'd1;
            if (count_q == LAST_STEP) begin
               {hi_d, lo_d} = neg_quo_q ? -step : step;
               dest_d       = 2'b11;
               count_d      = 5'd0;
               state_d      = DONE;
            end
`else
            state_d = IDLE;
`endif
         end

         DONE: begin
            if (mdu.out_ready) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         count_d = 5'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= 5'd0;
         acc_hi_q   <= 32'd0;
         acc_lo_q   <= 32'd0;
         opb_q      <= 32'd0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         dest_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opb_q      <= opb_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dest_q     <= dest_d;
      end
   end

   assign mdu.in_ready  = (state_q == IDLE);
   assign mdu.out_valid = (state_q == DONE);
   assign mdu.busy      = (state_q != IDLE);
   assign mdu.out_hi    = hi_q;
   assign mdu.out_lo    = lo_q;
   assign mdu.out_dest  = dest_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb_mdu_hilo_unit: self-checking bench for mdu_hilo_unit.
// Latency: n/a (testbench).
// Backpressure: exercises held out_ready, flush and reset while dividing.
module tb_mdu_hilo_unit;
   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   mdu_hilo_unit_if mif();

   mdu_hilo_unit #(.DIV_STEPS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .mdu   (mif)
   );

`ifdef MDU_ITER_MUL_EN
   localparam int MUL_LAT = 32;
`else
   localparam int MUL_LAT = 1;
`endif
   localparam int DIV_LAT = 32;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [1:0]  dest;
      int          lat;
   } vec_t;

   vec_t vt [0:17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: architectural HI/LO results from plain arithmetic.
   task automatic ref_model(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                            output logic [31:0] hi, output logic [31:0] lo,
                            output logic [1:0] dest, output int lat);
      logic [63:0] p;
      int a, b;
      a = s1;
      b = s2;
      hi = 32'd0; lo = 32'd0; dest = 2'b11; lat = 1;
      case (op)
         3'd0: begin p = 64'(longint'(a) * longint'(b)); {hi, lo} = p; lat = MUL_LAT; end
         3'd1: begin p = {32'd0, s1} * {32'd0, s2}; {hi, lo} = p; lat = MUL_LAT; end
         3'd2: begin
            lat = DIV_LAT;
            if (s2 == 32'd0) begin lo = 32'hFFFF_FFFF; hi = s1; end
            else if (s1 == 32'h8000_0000 && s2 == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'd0; end
            else begin lo = a / b; hi = a % b; end
         end
         3'd3: begin
            lat = DIV_LAT;
            if (s2 == 32'd0) begin lo = 32'hFFFF_FFFF; hi = s1; end
            else begin lo = s1 / s2; hi = s1 % s2; end
         end
         3'd4: begin hi = s1; dest = 2'b01; end
         3'd5: begin lo = s1; dest = 2'b10; end
         default: dest = 2'b00;
      endcase
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Waits (bounded) for in_ready, presents the op for one accept edge, then scrambles inputs.
   task automatic start_op(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2);
      int n;
      n = 0;
      while (mif.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
      chk("accept_ready", mif.in_ready, 1);
      mif.in_valid = 1'b1;
      mif.in_op    = op;
      mif.in_src1  = s1;
      mif.in_src2  = s2;
      tick();
      mif.in_valid = 1'b0;
      mif.in_op    = 3'($urandom_range(0, 7));
      mif.in_src1  = $urandom;
      mif.in_src2  = $urandom;
   endtask

   // Counts cycles from accept to out_valid; stall_ok drops if busy/in_ready misbehave meanwhile.
   task automatic wait_result(output int lat, output bit stall_ok);
      lat = 1;
      stall_ok = 1'b1;
      while (mif.out_valid !== 1'b1 && lat < 80) begin
         if (mif.busy !== 1'b1 || mif.in_ready !== 1'b0) stall_ok = 1'b0;
         tick();
         lat++;
      end
   endtask

   task automatic consume();
      mif.out_ready = 1'b1;
      tick();
      mif.out_ready = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic [1:0] edest, input int elat);
      int lat;
      bit ok;
      start_op(op, s1, s2);
      wait_result(lat, ok);
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_hilo"}, {mif.out_hi, mif.out_lo}, {ehi, elo});
      chk({tag, "_dest"}, mif.out_dest, edest);
      if (elat > 1) chk({tag, "_stall"}, ok, 1);
      consume();
   endtask

   initial begin
      logic [31:0] hi0, lo0, ehi, elo;
      logic [1:0]  dest0, edest;
      logic [2:0]  rop;
      logic [31:0] rs1, rs2;
      int          elat, lat;
      bit          ok, stable, seen;

      vt[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 2'b11, MUL_LAT};
      vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b11, MUL_LAT};
      vt[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2'b11, MUL_LAT};
      vt[3]  = '{3'd0, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2'b11, MUL_LAT};
      vt[4]  = '{3'd1, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         2'b11, MUL_LAT};
      vt[5]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'b11, DIV_LAT};
      vt[6]  = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 2'b11, DIV_LAT};
      vt[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 2'b11, DIV_LAT};
      vt[8]  = '{3'd2, 32'd9,         32'd3,         32'd0,         32'd3,         2'b11, DIV_LAT};
      vt[9]  = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         2'b11, DIV_LAT};
      vt[10] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 2'b11, DIV_LAT};
      vt[11] = '{3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 2'b11, DIV_LAT};
      vt[12] = '{3'd2, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 2'b11, DIV_LAT};
      vt[13] = '{3'd3, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, 2'b11, DIV_LAT};
      vt[14] = '{3'd4, 32'h0000_1234, 32'd5,         32'h0000_1234, 32'd0,         2'b01, 1};
      vt[15] = '{3'd5, 32'h0000_ABCD, 32'd5,         32'd0,         32'h0000_ABCD, 2'b10, 1};
      vt[16] = '{3'd6, 32'h1111_1111, 32'h2222_2222, 32'd0,         32'd0,         2'b00, 1};
      vt[17] = '{3'd7, 32'h3333_3333, 32'h4444_4444, 32'd0,         32'd0,         2'b00, 1};

      reset = 1'b1; flush = 1'b0;
      mif.in_valid = 1'b0; mif.in_op = 3'd0; mif.in_src1 = 32'd0; mif.in_src2 = 32'd0;
      mif.out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", mif.out_valid, 0);
      chk("rst_busy", mif.busy, 0);
      chk("rst_in_ready", mif.in_ready, 1);
      chk("rst_hilo", {mif.out_hi, mif.out_lo}, 64'd0);
      chk("rst_dest", mif.out_dest, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 18; i++)
         run_check($sformatf("vec%0d", i), vt[i].op, vt[i].s1, vt[i].s2,
                   vt[i].hi, vt[i].lo, vt[i].dest, vt[i].lat);

      // Backpressure: result and in_ready must hold while out_ready stays low.
      start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_result(lat, ok);
      chk("bp_lat", 64'(lat), 64'(DIV_LAT));
      chk("bp_stall", ok, 1);
      hi0 = mif.out_hi; lo0 = mif.out_lo; dest0 = mif.out_dest;
      chk("bp_hilo", {hi0, lo0}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      stable = 1'b1;
      repeat (5) begin
         tick();
         if (mif.out_hi !== hi0 || mif.out_lo !== lo0 || mif.out_dest !== dest0 ||
             mif.out_valid !== 1'b1 || mif.in_ready !== 1'b0) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
      consume();
      chk("bp_release_idle", {mif.busy, mif.in_ready, mif.out_valid}, 3'b010);
      run_check("bp_mthi", 3'd4, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'd0, 2'b01, 1);

      // Flush at count 10 with a competing op presented in the same cycle.
      start_op(3'd2, 32'd100, 32'd7);
      repeat (9) tick();
      flush = 1'b1;
      mif.in_valid = 1'b1; mif.in_op = 3'd4; mif.in_src1 = 32'hDEAD_0001;
      tick();
      flush = 1'b0; mif.in_valid = 1'b0;
      chk("flush_idle", {mif.busy, mif.in_ready, mif.out_valid}, 3'b010);
      seen = 1'b0;
      repeat (40) begin if (mif.out_valid) seen = 1'b1; tick(); end
      chk("flush_no_valid", seen, 0);
      run_check("flush_div", 3'd2, 32'd9, 32'd3, 32'd0, 32'd3, 2'b11, DIV_LAT);

      // Same with reset: outputs also return to their reset values.
      start_op(3'd2, 32'd100, 32'd7);
      repeat (9) tick();
      reset = 1'b1;
      mif.in_valid = 1'b1; mif.in_op = 3'd5; mif.in_src1 = 32'hDEAD_0002;
      tick();
      reset = 1'b0; mif.in_valid = 1'b0;
      chk("reset_idle", {mif.busy, mif.in_ready, mif.out_valid}, 3'b010);
      chk("reset_hilo", {mif.out_hi, mif.out_lo}, 64'd0);
      chk("reset_dest", mif.out_dest, 0);
      seen = 1'b0;
      repeat (40) begin if (mif.out_valid) seen = 1'b1; tick(); end
      chk("reset_no_valid", seen, 0);
      run_check("reset_div", 3'd2, 32'd9, 32'd3, 32'd0, 32'd3, 2'b11, DIV_LAT);

      // Random ops against the reference model, with random consumer delay.
      for (int i = 0; i < 120; i++) begin
         rop = 3'($urandom_range(0, 7));
         rs1 = rnd_operand();
         rs2 = rnd_operand();
         ref_model(rop, rs1, rs2, ehi, elo, edest, elat);
         start_op(rop, rs1, rs2);
         wait_result(lat, ok);
         repeat ($urandom_range(0, 2)) tick();
         chk($sformatf("rnd%0d_op%0d_lat", i, rop), 64'(lat), 64'(elat));
         chk($sformatf("rnd%0d_op%0d_%h_%h_hilo", i, rop, rs1, rs2),
             {mif.out_hi, mif.out_lo}, {ehi, elo});
         chk($sformatf("rnd%0d_op%0d_dest", i, rop), mif.out_dest, edest);
         consume();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
